// File: rtl/sme_sched_pkg.sv
// Shared types and defaults for the SME front-end scheduler.
package sme_sched_pkg;

   localparam int STR_MAX_D = 32;
   localparam int PAT_MAX_D = 8;
   localparam int TIMEOUT_D = 255;

   localparam int STR_W  = 6;
   localparam int PAT_W  = 4;
   localparam int WAIT_W = 8;

   typedef logic [2:0] state_t;

   localparam state_t S_IDLE    = 3'd0;
   localparam state_t S_GRANT   = 3'd1;
   localparam state_t S_LOAD    = 3'd2;
   localparam state_t S_BURST_S = 3'd3;
   localparam state_t S_BURST_P = 3'd4;
   localparam state_t S_WAIT    = 3'd5;
   localparam state_t S_RESP    = 3'd6;

   localparam logic KIND_STR = 1'b0;
   localparam logic KIND_PAT = 1'b1;

   function automatic logic [1:0] owner_mask(input logic idx);
      return idx ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/sme_rr_arbiter.sv
// Two-way round-robin arbiter; the last-served pointer moves on each grant.
module sme_rr_arbiter (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req,
   input  logic       en,
   output logic       sel,
   output logic       any
);

   logic last;

   always_comb begin
      any = |req;
      sel = req[1] & (~req[0] | ~last);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         last <= 1'b1;
      end else if (en && any) begin
         last <= sel;
      end
   end

endmodule

// File: rtl/sme_scheduler.sv
// SME front end: arbitrates, buffers one job, replays it to the engine
// as a contiguous string/pattern burst and routes the result back.
module sme_scheduler
   import sme_sched_pkg::*;
#(
   parameter int STR_MAX = STR_MAX_D,
   parameter int PAT_MAX = PAT_MAX_D,
   parameter int TIMEOUT = TIMEOUT_D
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req,
   output logic [1:0] gnt,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [7:0] in_char,
   input  logic       in_kind,
   input  logic       in_last,
   output logic [1:0] res_valid,
   output logic       res_match,
   output logic [4:0] res_index,
   output logic       res_err,
   output logic [7:0] eng_chardata,
   output logic       eng_isstring,
   output logic       eng_ispattern,
   input  logic       eng_valid,
   input  logic       eng_match,
   input  logic [4:0] eng_match_index
);

   localparam logic [STR_W-1:0]  SMAX = STR_W'(STR_MAX);
   localparam logic [PAT_W-1:0]  PMAX = PAT_W'(PAT_MAX);
   localparam logic [WAIT_W-1:0] TMO  = WAIT_W'(TIMEOUT);

   state_t            state;
   logic              owner;
   logic [STR_W-1:0]  s_len;
   logic [PAT_W-1:0]  p_len;
   logic [STR_W-1:0]  cnt;
   logic [WAIT_W-1:0] wcnt;
   logic              first;
   logic              pat_only;
   logic              seen_pat;
   logic              str_ovf;
   logic              pat_ovf;
   logic              bad_order;
   logic              str_valid;
   logic              str_owner;

   logic [7:0] str_buf [STR_MAX];
   logic [7:0] pat_buf [PAT_MAX];

   logic       arb_sel;
   logic       arb_any;
   logic       acc;
   logic       is_pat;
   logic       n_pat_only;
   logic       job_err;
   logic [7:0] pat0;

   sme_rr_arbiter u_arb (
      .clk   (clk),
      .reset (reset),
      .req   (req),
      .en    (state == S_IDLE),
      .sel   (arb_sel),
      .any   (arb_any)
   );

   // Error status including the beat being accepted right now.
   always_comb begin
      acc        = (state == S_LOAD) && in_valid && in_ready;
      is_pat     = (in_kind == KIND_PAT);
      n_pat_only = first ? is_pat : pat_only;
      job_err    = bad_order
                 | (seen_pat & ~is_pat)
                 | str_ovf
                 | (~is_pat & ~seen_pat & (s_len == SMAX))
                 | pat_ovf
                 | (is_pat & (p_len == PMAX))
                 | ((p_len == '0) & ~is_pat)
                 | (n_pat_only & ~(str_valid & (str_owner == owner)));
      pat0       = (p_len == '0) ? in_char : pat_buf[0];
   end

   always_ff @(posedge clk) begin
      if (acc && !is_pat && !seen_pat && s_len != SMAX) begin
         str_buf[s_len[4:0]] <= in_char;
      end
      if (acc && is_pat && p_len != PMAX) begin
         pat_buf[p_len[2:0]] <= in_char;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state         <= S_IDLE;
         owner         <= 1'b0;
         gnt           <= '0;
         in_ready      <= 1'b0;
         res_valid     <= '0;
         res_match     <= 1'b0;
         res_index     <= '0;
         res_err       <= 1'b0;
         eng_chardata  <= '0;
         eng_isstring  <= 1'b0;
         eng_ispattern <= 1'b0;
         s_len         <= '0;
         p_len         <= '0;
         cnt           <= '0;
         wcnt          <= '0;
         first         <= 1'b0;
         pat_only      <= 1'b0;
         seen_pat      <= 1'b0;
         str_ovf       <= 1'b0;
         pat_ovf       <= 1'b0;
         bad_order     <= 1'b0;
         str_valid     <= 1'b0;
         str_owner     <= 1'b0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (arb_any) begin
                  gnt   <= owner_mask(arb_sel);
                  owner <= arb_sel;
                  state <= S_GRANT;
               end
            end
            S_GRANT: begin
               in_ready  <= 1'b1;
               s_len     <= '0;
               p_len     <= '0;
               first     <= 1'b1;
               pat_only  <= 1'b0;
               seen_pat  <= 1'b0;
               str_ovf   <= 1'b0;
               pat_ovf   <= 1'b0;
               bad_order <= 1'b0;
               state     <= S_LOAD;
            end
            S_LOAD: begin
               if (acc) begin
                  first <= 1'b0;
                  if (first) pat_only <= is_pat;
                  if (is_pat) begin
                     seen_pat <= 1'b1;
                     if (p_len == PMAX) pat_ovf <= 1'b1;
                     else p_len <= p_len + 4'd1;
                  end else if (seen_pat) begin
                     bad_order <= 1'b1;
                  end else begin
                     // The buffer is being overwritten; old string is gone.
                     str_valid <= 1'b0;
                     if (s_len == SMAX) str_ovf <= 1'b1;
                     else s_len <= s_len + 6'd1;
                  end
                  if (in_last) begin
                     in_ready <= 1'b0;
                     cnt      <= 6'd1;
                     if (job_err) begin
                        res_valid <= owner_mask(owner);
                        res_err   <= 1'b1;
                        state     <= S_RESP;
                     end else if (n_pat_only) begin
                        eng_ispattern <= 1'b1;
                        eng_chardata  <= pat0;
                        state         <= S_BURST_P;
                     end else begin
                        eng_isstring <= 1'b1;
                        eng_chardata <= str_buf[0];
                        state        <= S_BURST_S;
                     end
                  end
               end
            end
            S_BURST_S: begin
               if (cnt == s_len) begin
                  eng_isstring  <= 1'b0;
                  eng_ispattern <= 1'b1;
                  eng_chardata  <= pat_buf[0];
                  cnt           <= 6'd1;
                  str_valid     <= 1'b1;
                  str_owner     <= owner;
                  state         <= S_BURST_P;
               end else begin
                  eng_chardata <= str_buf[cnt[4:0]];
                  cnt          <= cnt + 6'd1;
               end
            end
            S_BURST_P: begin
               if (cnt == {2'b00, p_len}) begin
                  eng_ispattern <= 1'b0;
                  eng_chardata  <= '0;
                  wcnt          <= '0;
                  state         <= S_WAIT;
               end else begin
                  eng_chardata <= pat_buf[cnt[2:0]];
                  cnt          <= cnt + 6'd1;
               end
            end
            S_WAIT: begin
               if (eng_valid) begin
                  res_valid <= owner_mask(owner);
                  res_match <= eng_match;
                  res_index <= eng_match_index;
                  state     <= S_RESP;
               end else if (wcnt == TMO) begin
                  res_valid <= owner_mask(owner);
                  res_err   <= 1'b1;
                  str_valid <= 1'b0;
                  state     <= S_RESP;
               end else begin
                  wcnt <= wcnt + 8'd1;
               end
            end
            S_RESP: begin
               res_valid <= '0;
               res_match <= 1'b0;
               res_index <= '0;
               res_err   <= 1'b0;
               gnt       <= '0;
               state     <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sme_scheduler.sv
// Directed bench for sme_scheduler; the bench plays both requesters
// and the engine, checking bursts and routed results.
module tb_sme_scheduler;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [1:0] req = '0;
   logic       in_valid = 1'b0;
   logic [7:0] in_char = '0;
   logic       in_kind = 1'b0;
   logic       in_last = 1'b0;
   logic       eng_valid = 1'b0;
   logic       eng_match = 1'b0;
   logic [4:0] eng_match_index = '0;
   logic [1:0] gnt;
   logic       in_ready;
   logic [1:0] res_valid;
   logic       res_match;
   logic [4:0] res_index;
   logic       res_err;
   logic [7:0] eng_chardata;
   logic       eng_isstring;
   logic       eng_ispattern;

   int    n_chk = 0;
   int    n_fail = 0;
   int    n_s, n_p, gap, bad_c;
   logic  prev_s = 1'b0;
   string exp_s = "";
   string exp_p = "";
   int    wc;

   sme_scheduler dut (
      .clk             (clk),
      .reset           (reset),
      .req             (req),
      .gnt             (gnt),
      .in_valid        (in_valid),
      .in_ready        (in_ready),
      .in_char         (in_char),
      .in_kind         (in_kind),
      .in_last         (in_last),
      .res_valid       (res_valid),
      .res_match       (res_match),
      .res_index       (res_index),
      .res_err         (res_err),
      .eng_chardata    (eng_chardata),
      .eng_isstring    (eng_isstring),
      .eng_ispattern   (eng_ispattern),
      .eng_valid       (eng_valid),
      .eng_match       (eng_match),
      .eng_match_index (eng_match_index)
   );

   always #5 clk = ~clk;

   // Engine-side monitor: chars, burst lengths and string->pattern gaps.
   always @(posedge clk) begin
      if (eng_isstring) begin
         if (n_s >= exp_s.len() || eng_chardata != exp_s[n_s]) bad_c++;
         n_s++;
      end
      if (eng_ispattern) begin
         if (n_p >= exp_p.len() || eng_chardata != exp_p[n_p]) bad_c++;
         n_p++;
      end
      if (eng_isstring && eng_ispattern) bad_c++;
      if (prev_s && !eng_isstring && !eng_ispattern) gap++;
      prev_s = eng_isstring;
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic job(input string tag, input logic [1:0] rq, input int r,
                      input string s, input string p, input int dly,
                      input logic m, input logic [4:0] idx,
                      input logic e_err, input logic eng_act,
                      output int wcount);
      int total, nr, cyc, d;
      logic seen_p, fired, got;
      logic [1:0] mask;
      mask = (r == 1) ? 2'b10 : 2'b01;
      exp_s = s; exp_p = p;
      n_s = 0; n_p = 0; gap = 0; bad_c = 0;
      req = rq;
      tick;
      chk({tag, ".gnt"}, gnt, mask);
      req = 2'b00;
      tick;
      chk({tag, ".rdy"}, in_ready, 1);
      total = s.len() + p.len();
      nr = 0;
      for (int i = 0; i < total; i++) begin
         if (i % 3 == 2) begin
            in_valid = 1'b0;
            tick;
         end
         if (!in_ready) nr++;
         in_valid = 1'b1;
         in_kind  = (i >= s.len());
         in_char  = (i < s.len()) ? s[i] : p[i - s.len()];
         in_last  = (i == total - 1);
         tick;
      end
      in_valid = 1'b0; in_last = 1'b0; in_kind = 1'b0;
      chk({tag, ".acc"}, nr, 0);
      chk({tag, ".rdy0"}, in_ready, 0);
      if (eng_act)
         chk({tag, ".start"}, (s.len() > 0) ? eng_isstring : eng_ispattern, 1);
      seen_p = 0; fired = 0; got = 0; wcount = 0; d = dly; cyc = 0;
      while (!got && cyc < 600) begin
         if (res_valid != 2'b00) begin
            got = 1;
         end else begin
            eng_valid = 1'b0;
            if (eng_ispattern) seen_p = 1;
            else if (seen_p) begin
               wcount++;
               if (dly >= 0 && !fired) begin
                  if (d == 0) begin
                     eng_valid = 1'b1;
                     eng_match = m;
                     eng_match_index = idx;
                     fired = 1;
                  end else d--;
               end
            end
            tick;
            cyc++;
         end
      end
      eng_valid = 1'b0;
      chk({tag, ".resp"}, got, 1);
      chk({tag, ".rv"}, res_valid, mask);
      chk({tag, ".match"}, res_match, e_err ? 1'b0 : m);
      chk({tag, ".idx"}, res_index, e_err ? 5'd0 : idx);
      chk({tag, ".err"}, res_err, e_err);
      chk({tag, ".ns"}, n_s, eng_act ? s.len() : 0);
      chk({tag, ".np"}, n_p, eng_act ? p.len() : 0);
      chk({tag, ".gap"}, gap, 0);
      chk({tag, ".chars"}, bad_c, 0);
      tick;
      chk({tag, ".rvoff"}, res_valid, 0);
      chk({tag, ".erroff"}, res_err, 0);
      chk({tag, ".gntoff"}, gnt, 0);
   endtask

   initial begin
      reset = 1'b0;
      tick; tick;
      chk("rst.gnt", gnt, 0);
      chk("rst.rdy", in_ready, 0);
      chk("rst.rv", res_valid, 0);
      chk("rst.err", res_err, 0);
      chk("rst.isstr", eng_isstring, 0);
      chk("rst.ispat", eng_ispattern, 0);
      chk("rst.char", eng_chardata, 0);
      reset = 1'b1;
      tick;

      job("arb0", 2'b11, 0, "xy", "y", 1, 1'b1, 5'd1, 1'b0, 1'b1, wc);
      job("arb1", 2'b11, 1, "pqrs", "rs", 0, 1'b1, 5'd2, 1'b0, 1'b1, wc);
      job("arb2", 2'b11, 0, "aaaa", "b", 3, 1'b0, 5'd0, 1'b0, 1'b1, wc);
      job("arb3", 2'b11, 1, "mnop", "op", 0, 1'b1, 5'd2, 1'b0, 1'b1, wc);

      job("basic", 2'b01, 0, "abcde", "cd", 0, 1'b1, 5'd2, 1'b0, 1'b1, wc);
      job("reuse0", 2'b01, 0, "", "b", 2, 1'b1, 5'd1, 1'b0, 1'b1, wc);
      job("reuse1", 2'b10, 1, "", "b", 0, 1'b0, 5'd0, 1'b1, 1'b0, wc);

      job("max", 2'b01, 0, "abcdefghijklmnopqrstuvwxyzABCDEF", "ABCDEFGH",
          1, 1'b1, 5'd31, 1'b0, 1'b1, wc);
      job("sovf", 2'b01, 0, "abcdefghijklmnopqrstuvwxyzABCDEFG", "a",
          0, 1'b0, 5'd0, 1'b1, 1'b0, wc);
      job("povf", 2'b01, 0, "abc", "abcdefghi", 0, 1'b0, 5'd0, 1'b1, 1'b0, wc);
      job("nopat", 2'b01, 0, "abc", "", 0, 1'b0, 5'd0, 1'b1, 1'b0, wc);

      job("tmo", 2'b10, 1, "hello", "l", -1, 1'b0, 5'd0, 1'b1, 1'b1, wc);
      chk("tmo.window", (wc >= 250 && wc <= 262), 1);
      job("tmoreuse", 2'b10, 1, "", "l", 0, 1'b0, 5'd0, 1'b1, 1'b0, wc);

      exp_s = "abcd"; exp_p = "a";
      req = 2'b01;
      tick;
      chk("mid.gnt", gnt, 2'b01);
      req = 2'b00;
      tick;
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         in_kind  = (i == 4);
         in_char  = 8'h61 + 8'(i);
         in_last  = (i == 4);
         tick;
      end
      in_valid = 1'b0; in_last = 1'b0; in_kind = 1'b0;
      chk("mid.isstr", eng_isstring, 1);
      tick;
      reset = 1'b0;
      tick;
      chk("mid.isstr0", eng_isstring, 0);
      chk("mid.ispat0", eng_ispattern, 0);
      chk("mid.gnt0", gnt, 0);
      chk("mid.rdy0", in_ready, 0);
      reset = 1'b1;
      req = 2'b11;
      tick;
      chk("mid.regnt", gnt, 2'b01);
      req = 2'b00;
      tick;

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/sme_scheduler.md
# sme_scheduler

Front-end scheduler for the string-matching engine (SME). Arbitrates two requesters round-robin, buffers one complete job (string up to 32 chars plus pattern up to 8 chars) from a bursty input stream, replays it to the engine as the contiguous `isstring`/`ispattern` burst the engine requires, and routes the engine's `valid`/`match`/`match_index` result back to the owning requester. It also provides string reuse, input validation and a result timeout.

## Interface
- `STR_MAX`, 32: max string length in chars.
- `PAT_MAX`, 8: max pattern length in chars.
- `TIMEOUT`, 255: max WAIT cycles before error.
- `clk`  in  1  sole clock.
- `reset`  in  1  synchronous, active-low reset.
- `req`  in  2  per-requester job request.
- `gnt`  out  2  one-hot grant, registered.
- `in_valid`  in  1  input beat valid; driven by the granted requester.
- `in_ready`  out  1  scheduler accepts a beat when `in_valid && in_ready`.
- `in_char`  in  8  character.
- `in_kind`  in  1  0 = string char, 1 = pattern char.
- `in_last`  in  1  last beat of the job.
- `res_valid`  out  2  one-hot, one-cycle result strobe to the owner.
- `res_match`  out  1  match flag.
- `res_index`  out  5  match index.
- `res_err`  out  1  job rejected or timed out.
- `eng_chardata`  out  8  to engine `chardata`.
- `eng_isstring`  out  1  to engine `isstring`.
- `eng_ispattern`  out  1  to engine `ispattern`.
- `eng_valid`  in  1  from engine `valid`.
- `eng_match`  in  1  from engine `match`.
- `eng_match_index`  in  5  from engine `match_index`.

## Operation
- **States:** IDLE → GRANT → LOAD → BURST_S → BURST_P → WAIT → RESP → IDLE. Error jobs skip from LOAD to RESP.
- **IDLE:** if any `req` is set, select a requester. With both set, select the one not served last; the pointer resets to favour requester 0.
- **GRANT:** assert the selected `gnt` bit. It holds through RESP. `req` is ignored while granted.
- **LOAD:**
  - `in_ready` = 1.
  - String beats (`in_kind` = 0) fill the string buffer; pattern beats fill the pattern buffer. String beats must precede pattern beats.
  - The beat with `in_last` ends LOAD.
- **Pattern-only job:** first beat has `in_kind` = 1. It reuses the resident string only if the resident string is valid and was loaded by the same requester.
- **Error conditions** (`res_err` = 1, no engine activity):
  - string length > `STR_MAX`;
  - pattern length > `PAT_MAX`;
  - pattern length = 0;
  - string beat after a pattern beat;
  - pattern-only job without a valid resident string owned by this requester.
- **Overflow:** on string or pattern overflow, keep accepting and discarding beats until `in_last`, then report the error.
- **BURST_S:** drive one string char per cycle with `eng_isstring` = 1, L cycles. Skipped for reuse jobs. Afterwards record resident string valid with owner = this requester.
- **BURST_P:** drive pattern chars with `eng_ispattern` = 1, P cycles. The first pattern cycle immediately follows the last string cycle (no gap).
- **WAIT:** count cycles. On `eng_valid`, capture match and index.
  - When the count reaches `TIMEOUT`: set `res_err`, invalidate the resident string.
  - `eng_valid` arriving in the same cycle as timeout wins.
- **RESP:** `res_valid[owner]` high for one cycle. The `res_*` fields are valid only with the strobe, else 0. An error job drives `res_match` = 0 and `res_index` = 0.
- **Reset values:**
  - all outputs 0;
  - state IDLE, resident string invalid, RR pointer = 1 (so requester 0 wins first).
- **Reset mid-job:** the job is dropped; the engine bus goes low next edge. The engine's own reset is external.

## Timing
- `req` sampled in IDLE → `gnt` high the next cycle (GRANT); `in_ready` high one cycle later (LOAD).
- Accepted last beat at cycle t → `eng_isstring` first high at t+1.
- Engine bus outputs are registered; widths and lengths are counted in 6-bit and 4-bit counters.
- `eng_valid` at cycle t → `res_valid` at t+1.
- `gnt` drops the cycle after `res_valid`.
- A new arbitration can happen in the cycle after that.
- Minimum job turnaround with 0 WAIT cycles: 3 + N_beats + L + P + 2 cycles.

## Structure
- **Package `sme_sched_pkg`:**
  - state enum;
  - `KIND_STR` / `KIND_PAT` constants;
  - `STR_MAX`, `PAT_MAX`, `TIMEOUT` defaults;
  - counter widths.
- **Sub-module `sme_rr_arbiter`:** 2-way round-robin with `last` pointer; update on grant.
- **Buffers:** string buffer 32×8 and pattern buffer 8×8, as flop arrays in the top level.

## Test plan
- **Basic job:** req[0] alone; string "abcde" (5 beats), pattern "cd" → eng_isstring 5 cycles, then eng_ispattern 2 cycles, no gap; eng_valid with match=1, index=2 → res_valid = 2'b01, res_match = 1, res_index = 2, res_err = 0.
- **Arbitration:** req = 2'b11 from reset → gnt = 2'b01 first, 2'b10 second. With req = 2'b11 again → order alternates.
- **String reuse:** pattern-only job "b" from requester 0 after its own job → no isstring cycles, ispattern 1 cycle. Same job from requester 1 → res_err = 1, no engine activity.
- **Overflow / empty pattern:**
  - 33 string chars + pattern "a" → all beats accepted, res_err = 1, engine idle.
  - string only (in_last on a string beat) → res_err = 1.
- **Timeout:** engine never responds → res_valid at WAIT count 255 with res_err = 1. Next pattern-only job from the same owner → res_err = 1.
- **Reset:** reset low during BURST_S → eng_isstring = 0 next cycle, gnt = 0, state IDLE.
